// File: rtl/mem_responder.sv
// Single-port word memory behind a req/ready handshake with a fixed number of wait states.
// Rejects misaligned or out-of-range addresses with err alongside the ready strobe.
module mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic [1:0]  fsm_state
);

  // Handshake: req is sampled only in IDLE; ready is a one-cycle completion strobe, err qualifies it.
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [3:0]     cnt;
  logic           cap_we;
  logic [31:0]    cap_adr;
  logic [31:0]    cap_wdata;
  logic [31:0]    mem [DEPTH_WORDS];
  logic           complete;
  logic           valid;
  logic [AW-1:0]  idx;

  assign complete = (state == BUSY) && (cnt == 4'd0);
  assign valid    = (cap_adr[1:0] == 2'b00) && (cap_adr[31:2] < 30'(DEPTH_WORDS));
  assign idx      = cap_adr[AW+1:2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = BUSY;
      BUSY:    if (cnt == 4'd0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ready     = (state == DONE);
    fsm_state = state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= 4'd0;
      cap_we    <= 1'b0;
      cap_adr   <= 32'h0;
      cap_wdata <= 32'h0;
      rdata     <= 32'h0;
      err       <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        cap_we    <= we;
        cap_adr   <= adr;
        cap_wdata <= wdata;
        cnt       <= 4'(WAIT_STATES);
      end
      if (state == BUSY && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (complete) begin
        err <= !valid;
        if (!valid)       rdata <= 32'h0;
        else if (!cap_we) rdata <= mem[idx];
      end
      if (state == DONE) err <= 1'b0;
    end
  end

  // Storage is deliberately not reset; the reset gate blocks a write from an aborted transaction.
  always_ff @(posedge clk) begin
    if (reset && complete && valid && cap_we) mem[idx] <= cap_wdata;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, meaning number of 32-bit words stored; power of two, 4..1024.
REQ-002 Parameter WAIT_STATES, default 2, meaning extra cycles inserted before each response; range 0..15.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port req  input  1  processor access request; held high until ready.
REQ-006 Port we  input  1  1 = write, 0 = read (processor MemWrite).
REQ-007 Port adr  input  32  byte address (processor Adr).
REQ-008 Port wdata  input  32  write data (processor WriteData).
REQ-009 Port rdata  output  32  read data (processor ReadData); registered.
REQ-010 Port ready  output  1  one-cycle response strobe; transaction complete.
REQ-011 Port err  output  1  valid only with ready; access rejected.

Function
REQ-012 FSM states IDLE, BUSY, DONE; IDLE -> BUSY on req=1 at a rising edge; BUSY -> DONE when wait counter = 0; DONE -> IDLE unconditionally after one cycle.
REQ-013 On IDLE->BUSY edge: capture adr, we, wdata into internal registers; load wait counter with WAIT_STATES.
REQ-014 Captured values are used for the whole transaction; changes on adr/we/wdata/req after capture are ignored.
REQ-015 BUSY: counter decrements by 1 per cycle while nonzero; WAIT_STATES=0 means BUSY lasts exactly one cycle.
REQ-016 Latency: req sampled at edge N -> ready high in the cycle after edge N+WAIT_STATES+1 (WAIT_STATES=2: ready in cycle after edge N+3).
REQ-017 ready high for exactly one cycle (the DONE state); low in IDLE and BUSY.
REQ-018 Word index = adr[31:2]; valid when adr[1:0]=2'b00 and adr[31:2] < DEPTH_WORDS.
REQ-019 Valid write: memory word updated with captured wdata on the BUSY->DONE edge; rdata unchanged; err=0.
REQ-020 Valid read: rdata loaded with memory word on the BUSY->DONE edge; held until the next read response or reset; err=0.
REQ-021 Misaligned (adr[1:0]!=0) or out-of-range access: err=1 with ready; no memory write; rdata loaded with 32'h0.
REQ-022 Read of a word written by an earlier completed transaction returns the new value (no stale data).
REQ-023 req not sampled in BUSY or DONE; a new request is accepted only in IDLE, so minimum spacing between ready pulses = WAIT_STATES+3 cycles.
REQ-024 req still high in IDLE after DONE is treated as a new request; requester drops req in the cycle it sees ready unless issuing another access.
REQ-025 req=0 while in BUSY does not abort; transaction completes and ready pulses.

Reset
REQ-026 reset=0 forces asynchronously: state IDLE, counter 0, ready 0, err 0, rdata 32'h0, captured registers 0.
REQ-027 Memory array not reset; contents retained across reset, undefined after power-up.
REQ-028 Reset asserted in BUSY before the BUSY->DONE edge: transaction aborted, no memory write, no ready pulse.
REQ-029 After reset release, first rising edge with req=1 starts a transaction normally.

Verification
REQ-030 WAIT_STATES=2: write adr=0x10 wdata=0xDEADBEEF, then read adr=0x10 -> ready in cycle after edge N+3 each, read rdata=0xDEADBEEF, err=0.
REQ-031 Read adr=0x102 (misaligned) -> ready with err=1, rdata=0x0; subsequent read of word 0x100 (index 64 with DEPTH_WORDS=64) -> err=1, no write.
REQ-032 Write adr=0x20 wdata=0x1; change wdata to 0x2 and adr to 0x24 in BUSY -> word 0x20 = 0x1, word 0x24 untouched.
REQ-033 Write adr=0x30 wdata=0x55; assert reset=0 in BUSY cycle 1 -> ready never pulses, later read of 0x30 returns prior value.
REQ-034 WAIT_STATES=0: req held high continuously -> ready pulses every 3 cycles, one cycle wide, alternate write/read of 0x0 with 0xA5A5A5A5 returns 0xA5A5A5A5.
REQ-035 Hold req high through two transactions at default parameters -> exactly two ready pulses 5 cycles apart, no duplicate write.
